// File: rtl/gf_int_mult_compare.sv
// gf_int_mult_compare
//   Registered multiplier cross-check block. One operand pair is multiplied by
//   three independent architectures in parallel. Each result is registered
//   with a latency of 1 cycle. gf_option selects the arithmetic:
//     0 = unsigned integer product
//     1 = carry-less GF(2)[x] product, with no reduction.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset; it clears all outputs
//   gf_option  0 = integer, 1 = carry-less; sampled together with a and b
//   a, b       DATA_WIDTH-bit operands (bit i = x^i in carry-less mode)
//   out        result from the partial-product tree (2*DATA_WIDTH bits)
//   out2       result from the unrolled shift-and-accumulate loop
//   out3       result from the one-level Karatsuba split
//   mismatch   (only when GF_MULT_CMP_MISMATCH_EN is defined) registered
//              flag: the three combinational results disagreed
//
// Optional feature macro: GF_MULT_CMP_MISMATCH_EN
module gf_int_mult_compare #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      gf_option,
  input  logic [DATA_WIDTH-1:0]     a,
  input  logic [DATA_WIDTH-1:0]     b,
  output logic [2*DATA_WIDTH-1:0]   out,
  output logic [2*DATA_WIDTH-1:0]   out2,
  output logic [2*DATA_WIDTH-1:0]   out3
`ifdef GF_MULT_CMP_MISMATCH_EN
  ,
  output logic                      mismatch
`endif
);

  localparam int RW = 2 * DATA_WIDTH;          // result width
  localparam int L  = DATA_WIDTH / 2;          // low split width
  localparam int H  = DATA_WIDTH - L;          // high split width (H >= L)
  localparam int HP = H + 1;                   // width of aL+aH without truncation
  localparam int KW = 2 * HP;                  // width of any Karatsuba sub-product
  localparam int NP = 1 << $clog2(DATA_WIDTH); // tree leaves, padded to a power of 2

  // ---------------------------------------------------------------------------
  // Architecture 1: partial-product array reduced by a balanced binary tree.
  // This is a heap layout: node 0 is the root, and nodes NP-1.. are the leaves.
  // Every partial sum is bounded by the full product, so RW bits never overflow.
  // ---------------------------------------------------------------------------
  logic [RW-1:0] node [2*NP-1];

  genvar gi;
  for (gi = 0; gi < NP; gi++) begin : g_leaf
    if (gi < DATA_WIDTH) begin : g_pp
      assign node[NP-1+gi] = (RW'(a) & {RW{b[gi]}}) << gi;
    end else begin : g_pad
      assign node[NP-1+gi] = '0;
    end
  end

  for (gi = 0; gi < NP-1; gi++) begin : g_node
    assign node[gi] = gf_option ? (node[2*gi+1] ^ node[2*gi+2])
                                : (node[2*gi+1] + node[2*gi+2]);
  end

  // ---------------------------------------------------------------------------
  // Architecture 2: shift-and-accumulate, fully unrolled.
  // ---------------------------------------------------------------------------
  logic [RW-1:0] acc;

  always_comb begin
    acc = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (b[i]) acc = gf_option ? (acc ^ (RW'(a) << i)) : (acc + (RW'(a) << i));
    end
  end

  // ---------------------------------------------------------------------------
  // Architecture 3: one level of Karatsuba.
  // The sub-operands are widened to HP bits so that aL+aH keeps its carry.
  // All three sub-products use KW bits, and KW <= RW holds for DATA_WIDTH >= 2.
  // ---------------------------------------------------------------------------
  function automatic logic [KW-1:0] clmul(input logic [HP-1:0] x,
                                          input logic [HP-1:0] y);
    logic [KW-1:0] r;
    r = '0;
    for (int i = 0; i < HP; i++) begin
      if (y[i]) r = r ^ (KW'(x) << i);
    end
    return r;
  endfunction

  logic [L-1:0]  a_lo, b_lo;
  logic [H-1:0]  a_hi, b_hi;
  logic [HP-1:0] a_sum, b_sum;
  logic [KW-1:0] ll, hh, mm, mid;
  logic [RW-1:0] kara;

  always_comb begin
    a_lo = a[L-1:0];
    b_lo = b[L-1:0];
    a_hi = a[DATA_WIDTH-1:L];
    b_hi = b[DATA_WIDTH-1:L];
    if (gf_option) begin
      a_sum = HP'(a_lo) ^ HP'(a_hi);
      b_sum = HP'(b_lo) ^ HP'(b_hi);
      ll    = clmul(HP'(a_lo), HP'(b_lo));
      hh    = clmul(HP'(a_hi), HP'(b_hi));
      mm    = clmul(a_sum, b_sum);
      mid   = mm ^ hh ^ ll;
      kara  = (RW'(hh) << (2*L)) ^ (RW'(mid) << L) ^ RW'(ll);
    end else begin
      a_sum = HP'(a_lo) + HP'(a_hi);
      b_sum = HP'(b_lo) + HP'(b_hi);
      ll    = KW'(a_lo) * KW'(b_lo);
      hh    = KW'(a_hi) * KW'(b_hi);
      mm    = KW'(a_sum) * KW'(b_sum);
      // mid = aL*bH + aH*bL. It is non-negative and smaller than mm, so it fits in KW.
      mid   = mm - hh - ll;
      kara  = (RW'(hh) << (2*L)) + (RW'(mid) << L) + RW'(ll);
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out  <= '0;
      out2 <= '0;
      out3 <= '0;
`ifdef GF_MULT_CMP_MISMATCH_EN
      mismatch <= 1'b0;
`endif
    end else begin
      out  <= node[0];
      out2 <= acc;
      out3 <= kara;
`ifdef GF_MULT_CMP_MISMATCH_EN
      mismatch <= (node[0] != acc) || (node[0] != kara);
`endif
    end
  end

endmodule

// File: tb/tb_gf_int_mult_compare.sv
// Testbench for gf_int_mult_compare. It builds three instances, with
// DATA_WIDTH 4, 5 (odd split) and 8. One operand pair drives all three
// instances; each instance takes the low bits it needs. Expected results come
// from a bit-level polynomial/integer reference model.
module tb_gf_int_mult_compare;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        gf;
  logic [3:0]  a4, b4;
  logic [4:0]  a5, b5;
  logic [7:0]  a8, b8;
  logic [7:0]  o4a, o4b, o4c;
  logic [9:0]  o5a, o5b, o5c;
  logic [15:0] o8a, o8b, o8c;
`ifdef GF_MULT_CMP_MISMATCH_EN
  logic        mm4, mm5, mm8;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gf_int_mult_compare #(.DATA_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .gf_option(gf), .a(a4), .b(b4),
    .out(o4a), .out2(o4b), .out3(o4c)
`ifdef GF_MULT_CMP_MISMATCH_EN
    , .mismatch(mm4)
`endif
  );

  gf_int_mult_compare #(.DATA_WIDTH(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .gf_option(gf), .a(a5), .b(b5),
    .out(o5a), .out2(o5b), .out3(o5c)
`ifdef GF_MULT_CMP_MISMATCH_EN
    , .mismatch(mm5)
`endif
  );

  gf_int_mult_compare #(.DATA_WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .gf_option(gf), .a(a8), .b(b8),
    .out(o8a), .out2(o8b), .out3(o8c)
`ifdef GF_MULT_CMP_MISMATCH_EN
    , .mismatch(mm8)
`endif
  );

  // Reference model.
  //   Integer mode: plain multiplication.
  //   Carry-less mode: coefficient of x^k is the parity of the terms a_i*b_j with i+j=k.
  function automatic longint unsigned ref_mul(int w, longint unsigned x,
                                              longint unsigned y, bit g);
    longint unsigned r;
    r = 0;
    if (!g) return x * y;
    for (int i = 0; i < w; i++)
      for (int j = 0; j < w; j++)
        if (x[i] && y[j]) r[i+j] = ~r[i+j];
    return r;
  endfunction

  // Apply one operand pair on a falling edge. Then step past the next rising edge.
  task automatic drive(input logic [7:0] x, input logic [7:0] y, input bit g);
    @(negedge clk);
    a4 = x[3:0]; b4 = y[3:0];
    a5 = x[4:0]; b5 = y[4:0];
    a8 = x;      b8 = y;
    gf = g;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    a4 = 4'd15; b4 = 4'd13; a5 = 5'd31; b5 = 5'd31; a8 = 8'hff; b8 = 8'hff; gf = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (o4a !== 8'd0 || o4b !== 8'd0 || o4c !== 8'd0 ||
          o5a !== 10'd0 || o8a !== 16'd0 || o8c !== 16'd0) begin
        errors++;
        $display("FAIL reset cycle %0d: got %0d/%0d/%0d expected 0", c, o4a, o4b, o4c);
      end
`ifdef GF_MULT_CMP_MISMATCH_EN
      checks++;
      if (mm4 !== 1'b0) begin
        errors++;
        $display("FAIL reset_mismatch: got %b expected 0", mm4);
      end
`endif
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (o4a !== 8'd195 || o4b !== 8'd195 || o4c !== 8'd195) begin
      errors++;
      $display("FAIL reset_release: got %0d/%0d/%0d expected 195", o4a, o4b, o4c);
    end
  endtask

  task automatic test_int;
    logic [3:0] xs [3] = '{4'd12, 4'd5, 4'd15};
    logic [3:0] ys [3] = '{4'd10, 4'd9, 4'd13};
    logic [7:0] ex [3] = '{8'd120, 8'd45, 8'd195};
    for (int k = 0; k < 3; k++) begin
      drive({4'd0, xs[k]}, {4'd0, ys[k]}, 1'b0);
      checks++;
      if (o4a !== ex[k] || o4b !== ex[k] || o4c !== ex[k]) begin
        errors++;
        $display("FAIL int %0d*%0d: got %0d/%0d/%0d expected %0d",
                 xs[k], ys[k], o4a, o4b, o4c, ex[k]);
      end
    end
  endtask

  task automatic test_clmul;
    logic [3:0] xs [3] = '{4'd15, 4'd12, 4'd5};
    logic [3:0] ys [3] = '{4'd13, 4'd10, 4'd9};
    logic [7:0] ex [3] = '{8'd75, 8'd120, 8'd45};
    for (int k = 0; k < 3; k++) begin
      drive({4'd0, xs[k]}, {4'd0, ys[k]}, 1'b1);
      checks++;
      if (o4a !== ex[k] || o4b !== ex[k] || o4c !== ex[k]) begin
        errors++;
        $display("FAIL clmul %0d*%0d: got %0d/%0d/%0d expected %0d",
                 xs[k], ys[k], o4a, o4b, o4c, ex[k]);
      end
    end
  endtask

  task automatic test_back_to_back;
    bit         gs [3] = '{1'b0, 1'b1, 1'b0};
    logic [7:0] ex [3] = '{8'd195, 8'd75, 8'd195};
    for (int k = 0; k < 3; k++) begin
      drive(8'd15, 8'd13, gs[k]);
      checks++;
      if (o4a !== ex[k] || o4b !== ex[k] || o4c !== ex[k]) begin
        errors++;
        $display("FAIL b2b step %0d mode %0d: got %0d/%0d/%0d expected %0d",
                 k, gs[k], o4a, o4b, o4c, ex[k]);
      end
    end
  endtask

  task automatic test_edges;
    logic [7:0] xs [4] = '{8'd0, 8'd0, 8'd15, 8'd15};
    logic [7:0] ys [4] = '{8'd15, 8'd15, 8'd15, 8'd15};
    bit         gs [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] ex [4] = '{8'd0, 8'd0, 8'd225, 8'd85};
    for (int k = 0; k < 4; k++) begin
      drive(xs[k], ys[k], gs[k]);
      checks++;
      if (o4a !== ex[k] || o4b !== ex[k] || o4c !== ex[k]) begin
        errors++;
        $display("FAIL edge %0d*%0d mode %0d: got %0d/%0d/%0d expected %0d",
                 xs[k], ys[k], gs[k], o4a, o4b, o4c, ex[k]);
      end
    end
    // All-ones operands at the widest instance (integer mode).
    drive(8'hff, 8'hff, 1'b0);
    checks++;
    if (o8a !== 16'd65025 || o8b !== 16'd65025 || o8c !== 16'd65025) begin
      errors++;
      $display("FAIL edge_allones8: got %0d/%0d/%0d expected 65025", o8a, o8b, o8c);
    end
  endtask

  task automatic test_sweep4;
    logic [7:0] ex;
    for (int g = 0; g < 2; g++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++) begin
          drive(8'(x), 8'(y), g[0]);
          ex = 8'(ref_mul(4, x, y, g[0]));
          checks++;
          if (o4a !== ex || o4b !== ex || o4c !== ex) begin
            errors++;
            $display("FAIL sweep4 %0d*%0d mode %0d: got %0d/%0d/%0d expected %0d",
                     x, y, g, o4a, o4b, o4c, ex);
          end
          if (g == 1) begin
            checks++;
            if (o4a[7] !== 1'b0) begin
              errors++;
              $display("FAIL sweep4_msb %0d*%0d: got %b expected 0", x, y, o4a[7]);
            end
          end
`ifdef GF_MULT_CMP_MISMATCH_EN
          checks++;
          if (mm4 !== 1'b0) begin
            errors++;
            $display("FAIL sweep4_mismatch %0d*%0d: got %b expected 0", x, y, mm4);
          end
`endif
        end
  endtask

  task automatic test_random;
    logic [7:0]  x, y;
    bit          g;
    logic [9:0]  e5;
    logic [15:0] e8;
    for (int n = 0; n < 300; n++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      g = 1'($urandom);
      drive(x, y, g);
      e5 = 10'(ref_mul(5, x[4:0], y[4:0], g));
      e8 = 16'(ref_mul(8, x, y, g));
      checks++;
      if (o5a !== e5 || o5b !== e5 || o5c !== e5) begin
        errors++;
        $display("FAIL rand5 %0d*%0d mode %0d: got %0d/%0d/%0d expected %0d",
                 x[4:0], y[4:0], g, o5a, o5b, o5c, e5);
      end
      checks++;
      if (o8a !== e8 || o8b !== e8 || o8c !== e8) begin
        errors++;
        $display("FAIL rand8 %0d*%0d mode %0d: got %0d/%0d/%0d expected %0d",
                 x, y, g, o8a, o8b, o8c, e8);
      end
`ifdef GF_MULT_CMP_MISMATCH_EN
      checks++;
      if (mm5 !== 1'b0 || mm8 !== 1'b0) begin
        errors++;
        $display("FAIL rand_mismatch: got %b/%b expected 0/0", mm5, mm8);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_int();
    test_clmul();
    test_back_to_back();
    test_edges();
    test_sweep4();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
